mips32_ifetch: RTL and testbench
================================

# mips32_ifetch

- Decoupled instruction-fetch stage for the MIPS32 pipeline.
- Sits between instruction memory and the ID stage:
  - issues word-addressed fetches;
  - buffers returned instruction words with their next-PC in a small prefetch FIFO;
  - hands them to ID over a valid/ready handshake.
- Branch redirects from EX/MEM flush the buffer and squash in-flight fetches.
- A halt input stops new fetches.

## Interface
- DEPTH, 4: prefetch FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0: first fetch address after reset.
- clk1  input  1  single pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, valid for one cycle per fetch.
- imem_addr  output  32  word address of the fetch, valid with imem_req.
- imem_rvalid  input  1  response strobe, one cycle per request, in order.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- redirect  input  1  taken branch: flush and refetch from redirect_pc.
- redirect_pc  input  32  branch target word address.
- halt  input  1  level; while high no new requests are issued.
- if_valid  output  1  if_ir/if_npc hold a valid instruction.
- if_ir  output  32  instruction word to ID.
- if_npc  output  32  fetch address + 1.
- id_ready  input  1  ID accepts the entry when if_valid && id_ready.

## Operation
Reset values:
- pc = RESET_PC; FIFO empty, count = 0.
- No outstanding request; drop flag = 0.
- imem_req = 0, imem_addr = RESET_PC.
- if_valid = 0, if_ir = 0, if_npc = 0.

Outstanding requests:
- At most one request is outstanding.
- The slot is free when nothing is outstanding, or when imem_rvalid arrives this cycle.

Issue:
- Condition: slot free && !halt && !redirect && (count + wr - pop) < DEPTH && !(drop pending without rvalid).
- wr = response accepted into the FIFO this cycle; pop = if_valid && id_ready.
- On issue: imem_req = 1, imem_addr = pc, outstanding set, pc <= pc + 1. The 32-bit pc wraps modulo 2^32.

Response handling:
- If drop = 0, imem_rvalid writes {imem_rdata, addr + 1} into the FIFO. The address is the one latched at issue.
- If drop = 1, the response is discarded and drop clears.

Redirect (one cycle):
- FIFO flushed (count = 0, if_valid = 0 next cycle).
- pc <= redirect_pc.
- If a request is outstanding and no imem_rvalid arrives that cycle, drop <= 1.
- An imem_rvalid in the same cycle as redirect is discarded.
- A pop in the same cycle is ignored: flush wins, and ID must treat the instruction as squashed.
- The first request from redirect_pc is issued no earlier than the next cycle.

Halt:
- Blocks issue only.
- The outstanding response still lands in the FIFO, and the FIFO keeps draining to ID.
- Deasserting halt resumes fetching from pc.

Full/empty:
- Full: no issue.
- Empty: if_valid = 0 (except bypass, below).
- Simultaneous write and pop when full is legal; count is unchanged.

Mid-operation reset:
- Asserting rst_n low returns every register to its reset value immediately.
- Any later imem_rvalid belonging to a pre-reset request is a protocol violation by memory.

## Timing
- Request in cycle t; imem_rvalid earliest t+1, arbitrary latency after that.
- Without bypass:
  - an entry written at the rvalid edge t+k shows if_valid = 1 from cycle t+k+1;
  - fetch-to-ID latency = memory latency + 1.
- With 1-cycle memory and id_ready held high: one instruction per cycle. The next request issues in the same cycle as the previous response.
- All outputs except the bypass path are registered.
- Redirect to first imem_req from the new target is 1 cycle. With a drop pending, the first request comes in the cycle the discarded response arrives.

## Configuration
- IFETCH_BYPASS_EN defined:
  - when the FIFO is empty and an accepted response arrives, if_valid/if_ir/if_npc are driven combinationally from imem_rvalid/imem_rdata in that same cycle;
  - if id_ready is high, the entry is consumed and never written.
  - Latency = memory latency.
- Not defined: all outputs come from FIFO registers, as in Timing.

## Test plan
- Reset, RESET_PC = 0, 1-cycle memory returning Mem[a] = a + 100, id_ready = 1:
  - imem_addr 0, 1, 2… on consecutive cycles;
  - ID receives ir 100, 101, 102 with npc 1, 2, 3, one per cycle.
- id_ready = 0 for 10 cycles, DEPTH = 4:
  - exactly 4 entries buffered, imem_req stays low;
  - releasing id_ready delivers 100..103 in order with no gap or duplicate.
- 3-cycle memory, redirect to 40 while the fetch of address 5 is outstanding:
  - word 5 is discarded, FIFO empty;
  - next imem_addr = 40; ID sees ir 140, npc 41 first.
- redirect asserted in the same cycle as imem_rvalid and a pop:
  - the response is dropped and if_valid = 0 next cycle;
  - imem_addr = redirect_pc next cycle.
- halt raised while a fetch of address 7 is outstanding:
  - 107 is still delivered and no further requests appear;
  - lowering halt resumes with imem_addr 8.
- rst_n pulsed low mid-stream with 3 entries buffered:
  - if_valid = 0 and imem_req = 0 immediately;
  - first request after release is RESET_PC.

Source files
------------

// File: rtl/mips32_ifetch.sv
// MIPS32 decoupled instruction fetch: one outstanding imem request, prefetch FIFO feeding ID.
// Optional feature macro IFETCH_BYPASS_EN forwards a response straight to ID when the FIFO is empty.
module mips32_ifetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    output logic [31:0] if_ir,
    output logic [31:0] if_npc,
    input  logic        id_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LVL = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic             outstanding;
    logic             drop;
    logic             run;
    logic [31:0]      fifo_ir  [DEPTH];
    logic [31:0]      fifo_npc [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             fifo_empty;
    logic             resp_ok;
    logic [31:0]      resp_npc;
    logic             fifo_wr;
    logic             fifo_pop;
    logic [CNT_W:0]   level;
    logic             room;
    logic             slot_free;
    logic             drop_wait;
    logic             issue;

    // A response is kept only if it is not squashed by an earlier or a same-cycle redirect.
    always_comb begin
        fifo_empty = (count == '0);
        resp_ok    = imem_rvalid && !drop && !redirect;
        resp_npc   = req_addr + 32'd1;
        fifo_pop   = !fifo_empty && id_ready;
    end

`ifdef IFETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass   = resp_ok && fifo_empty;
        fifo_wr  = resp_ok && !(bypass && id_ready);
        if_valid = !fifo_empty || bypass;
        if_ir    = bypass ? imem_rdata : fifo_ir[rd_ptr];
        if_npc   = bypass ? resp_npc : fifo_npc[rd_ptr];
    end
`else
    always_comb begin
        fifo_wr  = resp_ok;
        if_valid = !fifo_empty;
        if_ir    = fifo_ir[rd_ptr];
        if_npc   = fifo_npc[rd_ptr];
    end
`endif

    // Room is judged on the occupancy after this cycle so the new request's word always fits.
    always_comb begin
        level     = {1'b0, count} + (CNT_W + 1)'(fifo_wr) - (CNT_W + 1)'(fifo_pop);
        room      = (level < DEPTH_LVL);
        slot_free = !outstanding || imem_rvalid;
        drop_wait = drop && !imem_rvalid;
        issue     = run && slot_free && !halt && !redirect && room && !drop_wait;
        imem_req  = issue;
        imem_addr = pc;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            run         <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ir[i]  <= '0;
                fifo_npc[i] <= '0;
            end
        end else begin
            run <= 1'b1;

            if (redirect) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + 32'd1;
            end

            if (issue) begin
                req_addr    <= pc;
                outstanding <= 1'b1;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end

            // The in-flight word of a squashed path must be swallowed when it finally returns.
            if (imem_rvalid) begin
                drop <= 1'b0;
            end else if (redirect && outstanding) begin
                drop <= 1'b1;
            end

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (fifo_wr) begin
                    fifo_ir[wr_ptr]  <= imem_rdata;
                    fifo_npc[wr_ptr] <= resp_npc;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
            end
        end
    end

endmodule

// File: tb/tb_mips32_ifetch.sv
// Bench for mips32_ifetch: behavioural memory (Mem[a] = a + 100) and an in-order fetch-stream model.
module tb_mips32_ifetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic        id_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cyc = 0;
    int mem_lat = 1;
    bit rand_lat = 1'b0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    bit          pend_stale[$];

    logic        s_req, s_valid, s_rvalid, rsp_stale;
    logic [31:0] s_addr, s_ir, s_npc;

    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] got_ir_q[$];
    logic [31:0] got_npc_q[$];
    int          got_cyc_q[$];
    int          rsp_acc = 0;
    int          pop_cnt = 0;

    mips32_ifetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .if_valid    (if_valid),
        .if_ir       (if_ir),
        .if_npc      (if_npc),
        .id_ready    (id_ready)
    );

    always #5 clk1 = ~clk1;

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        got_ir_q.delete();
        got_npc_q.delete();
        got_cyc_q.delete();
    endtask

    // One clock: memory answers at the falling edge, outputs sampled 1 ns later, state moves on the rising edge.
    task automatic step();
        int lat;
        @(negedge clk1);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        rsp_stale   = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0] + 32'd100;
            rsp_stale   = pend_stale[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            void'(pend_stale.pop_front());
        end
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = if_valid;
        s_ir     = if_ir;
        s_npc    = if_npc;
        s_rvalid = imem_rvalid;
        last_cyc = cyc;
        if (s_req) begin
            lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + lat);
            pend_stale.push_back(1'b0);
            req_addr_q.push_back(s_addr);
            req_cyc_q.push_back(cyc);
        end
        if (redirect) begin
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            rsp_acc = 0;
            pop_cnt = 0;
        end else begin
            if (s_rvalid && !rsp_stale) rsp_acc++;
            if (s_valid && id_ready) begin
                pop_cnt++;
                got_ir_q.push_back(s_ir);
                got_npc_q.push_back(s_npc);
                got_cyc_q.push_back(cyc);
            end
        end
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        halt        = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        pend_stale.delete();
        clear_logs();
        rsp_acc = 0;
        pop_cnt = 0;
        repeat (2) @(posedge clk1);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until_req(input logic [31:0] a, output bit found);
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            step();
            if (s_req && s_addr == a) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", if_valid); end
        checks++; if (if_ir !== 32'h0) begin failures++; $display("FAIL reset_ir: got %h expected 0", if_ir); end
        checks++; if (if_npc !== 32'h0) begin failures++; $display("FAIL reset_npc: got %h expected 0", if_npc); end
        apply_reset();
        mem_lat  = 1;
        id_ready = 1'b0;
        repeat (4) step();
        checks++;
        if (req_addr_q.size() == 0) begin
            failures++; $display("FAIL reset_first_req: got no request expected one at %h", RESET_PC);
        end else if (req_addr_q[0] !== RESET_PC) begin
            failures++; $display("FAIL reset_first_req: got %h expected %h", req_addr_q[0], RESET_PC);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        mem_lat  = 1;
        id_ready = 1'b1;
        repeat (14) step();
        checks++;
        if (req_addr_q.size() < 8 || got_ir_q.size() < 8) begin
            failures++;
            $display("FAIL stream_count: got reqs=%0d pops=%0d expected at least 8 each", req_addr_q.size(), got_ir_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (req_addr_q[i] !== 32'(i)) begin failures++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, req_addr_q[i], 32'(i)); end
                if (i > 0) begin
                    checks++; if (req_cyc_q[i] != req_cyc_q[i-1] + 1) begin failures++; $display("FAIL stream_req_gap[%0d]: got cycle %0d expected %0d", i, req_cyc_q[i], req_cyc_q[i-1] + 1); end
                end
                checks++; if (got_ir_q[i] !== 32'(100 + i)) begin failures++; $display("FAIL stream_ir[%0d]: got %0d expected %0d", i, got_ir_q[i], 100 + i); end
                checks++; if (got_npc_q[i] !== 32'(i + 1)) begin failures++; $display("FAIL stream_npc[%0d]: got %0d expected %0d", i, got_npc_q[i], i + 1); end
                checks++; if (got_cyc_q[i] != req_cyc_q[0] + 2 + i) begin failures++; $display("FAIL stream_pop_cycle[%0d]: got %0d expected %0d", i, got_cyc_q[i], req_cyc_q[0] + 2 + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_lat  = 1;
        id_ready = 1'b0;
        repeat (12) step();
        checks++; if (req_addr_q.size() != DEPTH) begin failures++; $display("FAIL full_req_count: got %0d expected %0d", req_addr_q.size(), DEPTH); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_req_low: got %0b expected 0", s_req); end
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL full_valid: got %0b expected 1", s_valid); end
        checks++; if (got_ir_q.size() != 0) begin failures++; $display("FAIL full_no_pop: got %0d pops expected 0", got_ir_q.size()); end
        id_ready = 1'b1;
        repeat (8) step();
        checks++;
        if (got_ir_q.size() < 6) begin
            failures++; $display("FAIL drain_count: got %0d pops expected at least 6", got_ir_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (got_ir_q[i] !== 32'(100 + i)) begin failures++; $display("FAIL drain_ir[%0d]: got %0d expected %0d", i, got_ir_q[i], 100 + i); end
                checks++; if (got_npc_q[i] !== 32'(i + 1)) begin failures++; $display("FAIL drain_npc[%0d]: got %0d expected %0d", i, got_npc_q[i], i + 1); end
                if (i > 0) begin
                    checks++; if (got_cyc_q[i] != got_cyc_q[i-1] + 1) begin failures++; $display("FAIL drain_gap[%0d]: got cycle %0d expected %0d", i, got_cyc_q[i], got_cyc_q[i-1] + 1); end
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        bit found;
        int c5;
        apply_reset();
        mem_lat  = 3;
        id_ready = 1'b1;
        run_until_req(32'd5, found);
        checks++;
        if (!found) begin
            failures++; $display("FAIL drop_find_req5: got no request for 5 expected one");
            return;
        end
        c5 = last_cyc;
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'd40;
        step();
        redirect = 1'b0;
        step();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL drop_flush_valid: got %0b expected 0", s_valid); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL drop_wait_req: got %0b expected 0", s_req); end
        step();
        checks++; if (!(s_req === 1'b1 && s_addr === 32'd40 && last_cyc == c5 + 3)) begin
            failures++; $display("FAIL drop_first_req: got req=%0b addr=%0d cycle=%0d expected req=1 addr=40 cycle=%0d", s_req, s_addr, last_cyc, c5 + 3);
        end
        repeat (10) step();
        checks++;
        if (got_ir_q.size() < 2) begin
            failures++; $display("FAIL drop_pops: got %0d pops expected at least 2", got_ir_q.size());
        end else begin
            checks++; if (got_ir_q[0] !== 32'd140 || got_npc_q[0] !== 32'd41) begin failures++; $display("FAIL drop_first_pop: got ir=%0d npc=%0d expected ir=140 npc=41", got_ir_q[0], got_npc_q[0]); end
            checks++; if (got_ir_q[1] !== 32'd141 || got_npc_q[1] !== 32'd42) begin failures++; $display("FAIL drop_second_pop: got ir=%0d npc=%0d expected ir=141 npc=42", got_ir_q[1], got_npc_q[1]); end
        end
    endtask

    task automatic test_redirect_same_cycle();
        apply_reset();
        mem_lat  = 1;
        id_ready = 1'b1;
        repeat (8) step();
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'd200;
        step();
        redirect = 1'b0;
        checks++; if (!(s_rvalid === 1'b1 && s_valid === 1'b1)) begin failures++; $display("FAIL same_setup: got rvalid=%0b valid=%0b expected both 1", s_rvalid, s_valid); end
        step();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL same_flush_valid: got %0b expected 0", s_valid); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'd200) begin failures++; $display("FAIL same_next_req: got req=%0b addr=%0d expected req=1 addr=200", s_req, s_addr); end
        repeat (4) step();
        checks++;
        if (got_ir_q.size() < 1) begin
            failures++; $display("FAIL same_pops: got 0 pops expected at least 1");
        end else if (got_ir_q[0] !== 32'd300 || got_npc_q[0] !== 32'd201) begin
            failures++; $display("FAIL same_first_pop: got ir=%0d npc=%0d expected ir=300 npc=201", got_ir_q[0], got_npc_q[0]);
        end
    endtask

    task automatic test_halt();
        bit found;
        apply_reset();
        mem_lat  = 3;
        id_ready = 1'b1;
        run_until_req(32'd7, found);
        checks++;
        if (!found) begin
            failures++; $display("FAIL halt_find_req7: got no request for 7 expected one");
            return;
        end
        clear_logs();
        halt = 1'b1;
        repeat (12) step();
        checks++; if (req_addr_q.size() != 0) begin failures++; $display("FAIL halt_no_req: got %0d requests expected 0", req_addr_q.size()); end
        checks++;
        if (got_ir_q.size() == 0) begin
            failures++; $display("FAIL halt_delivery: got 0 pops expected word 107");
        end else if (got_ir_q[got_ir_q.size()-1] !== 32'd107 || got_npc_q[got_npc_q.size()-1] !== 32'd8) begin
            failures++; $display("FAIL halt_delivery: got ir=%0d npc=%0d expected ir=107 npc=8", got_ir_q[got_ir_q.size()-1], got_npc_q[got_npc_q.size()-1]);
        end
        halt = 1'b0;
        step();
        checks++; if (s_req !== 1'b1 || s_addr !== 32'd8) begin failures++; $display("FAIL halt_resume: got req=%0b addr=%0d expected req=1 addr=8", s_req, s_addr); end
    endtask

    task automatic test_reset_mid();
        bit found;
        apply_reset();
        mem_lat  = 1;
        id_ready = 1'b0;
        found    = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (rsp_acc - pop_cnt == 3) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL midrst_fill: got %0d buffered expected 3", rsp_acc - pop_cnt); end
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %0b expected 0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %0b expected 0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL midrst_addr: got %h expected %h", imem_addr, RESET_PC); end
        apply_reset();
        id_ready = 1'b1;
        repeat (8) step();
        checks++;
        if (req_addr_q.size() == 0 || got_ir_q.size() == 0) begin
            failures++; $display("FAIL midrst_restart: got reqs=%0d pops=%0d expected both nonzero", req_addr_q.size(), got_ir_q.size());
        end else begin
            checks++; if (req_addr_q[0] !== RESET_PC) begin failures++; $display("FAIL midrst_first_req: got %h expected %h", req_addr_q[0], RESET_PC); end
            checks++; if (got_ir_q[0] !== RESET_PC + 32'd100 || got_npc_q[0] !== RESET_PC + 32'd1) begin failures++; $display("FAIL midrst_first_pop: got ir=%0d npc=%0d expected ir=%0d npc=%0d", got_ir_q[0], got_npc_q[0], RESET_PC + 32'd100, RESET_PC + 32'd1); end
        end
    endtask

    // Reference: requests and deliveries each walk consecutive addresses, restarting at every redirect target.
    task automatic test_random();
        logic [31:0] exp_req, exp_pop, tgt;
        int live, pops, halt_cnt;
        bit cur_redir, cur_ready, cur_halt, prev_redir;
        apply_reset();
        rand_lat   = 1'b1;
        exp_req    = RESET_PC;
        exp_pop    = RESET_PC;
        live       = 0;
        pops       = 0;
        halt_cnt   = 0;
        prev_redir = 1'b0;
        for (int n = 0; n < 800; n++) begin
            cur_ready = ($urandom_range(0, 9) < 7);
            if (halt_cnt > 0) begin
                cur_halt = 1'b1;
                halt_cnt--;
            end else begin
                cur_halt = 1'b0;
                if ($urandom_range(0, 24) == 0) halt_cnt = int'($urandom_range(1, 6));
            end
            cur_redir   = (n > 4) && ($urandom_range(0, 29) == 0);
            tgt         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom();
            id_ready    = cur_ready;
            halt        = cur_halt;
            redirect    = cur_redir;
            redirect_pc = tgt;
            step();
            if (prev_redir) begin
                checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush@%0d: got valid=%0b expected 0", last_cyc, s_valid); end
            end
            if (s_req) begin
                checks++; if (s_addr !== exp_req) begin failures++; $display("FAIL rnd_req_addr@%0d: got %h expected %h", last_cyc, s_addr, exp_req); end
                checks++; if (cur_halt || cur_redir) begin failures++; $display("FAIL rnd_req_blocked@%0d: got req=1 with halt=%0b redirect=%0b expected req=0", last_cyc, cur_halt, cur_redir); end
                exp_req = exp_req + 32'd1;
                live++;
                checks++; if (live > DEPTH) begin failures++; $display("FAIL rnd_occupancy@%0d: got %0d entries expected at most %0d", last_cyc, live, DEPTH); end
            end
            if (cur_redir) begin
                exp_req = tgt;
                exp_pop = tgt;
                live    = 0;
            end else if (s_valid && cur_ready) begin
                checks++; if (s_npc !== exp_pop + 32'd1) begin failures++; $display("FAIL rnd_npc@%0d: got %h expected %h", last_cyc, s_npc, exp_pop + 32'd1); end
                checks++; if (s_ir !== exp_pop + 32'd100) begin failures++; $display("FAIL rnd_ir@%0d: got %h expected %h", last_cyc, s_ir, exp_pop + 32'd100); end
                exp_pop = exp_pop + 32'd1;
                live--;
                pops++;
            end
            prev_redir = cur_redir;
        end
        redirect = 1'b0;
        halt     = 1'b0;
        rand_lat = 1'b0;
        checks++; if (pops < 50) begin failures++; $display("FAIL rnd_progress: got %0d deliveries expected at least 50", pops); end
    endtask

    initial begin
        @(posedge clk1);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got simulation still running at time limit expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
